// File: rtl/video_pkg.sv
// Shared types and default constants for the video pipeline reset logic.
package video_pkg;

   // Reset sequencer FSM states
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      SOFT      = 2'd3
   } rst_seq_state_t;

   // Default sequencer configuration
   localparam int RST_NUM_STAGES  = 3;
   localparam int RST_STAGE_DELAY = 16;
   localparam int RST_LOCK_FILTER = 8;
   localparam int RST_SOFT_HOLD   = 4;

   // Increment an 8-bit event counter, holding at all-ones instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear to 0.
module sync_bit (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Shift the asynchronous input through two flops in the destination domain
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   // Drive the synchronised level out
   always_comb begin
      q_o = sync_q;
   end

endmodule

// File: rtl/reset_sequencer.sv
// Releases the video pipeline stage resets in order once the pixel PLL lock
// has been qualified, and pulls them all back on lock loss or soft request.
module reset_sequencer
   import video_pkg::*;
#(
   parameter int NUM_STAGES  = RST_NUM_STAGES,
   parameter int STAGE_DELAY = RST_STAGE_DELAY,
   parameter int LOCK_FILTER = RST_LOCK_FILTER,
   parameter int SOFT_HOLD   = RST_SOFT_HOLD
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  pll_lock,
   input  logic                  soft_reset_req,
   output logic                  soft_reset_ack,
   output logic [NUM_STAGES-1:0] stage_reset_n,
   output logic                  all_ready,
   output logic [7:0]            lock_loss_cnt
);

   localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
   localparam int HOLD_W = $clog2(SOFT_HOLD + 1);
   localparam int LOCK_W = $clog2(LOCK_FILTER + 1);
   localparam int IDX_W  = $clog2(NUM_STAGES) + 1;

   localparam logic [DLY_W-1:0]  DLY_ZERO  = DLY_W'(0);
   localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);
   localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SOFT_HOLD - 1);
   localparam logic [LOCK_W-1:0] LOCK_ZERO = LOCK_W'(0);
   localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
   localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_FILTER);
   localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

   // Synchronised lock and derived qualifiers
   logic lock_s;
   logic lock_ok_s;
   logic lock_lost_s;

   // State, counters and registered outputs
   rst_seq_state_t        state_q,     state_d;
   logic [LOCK_W-1:0]     lock_cnt_q,  lock_cnt_d;
   logic [DLY_W-1:0]      dly_q,       dly_d;
   logic [HOLD_W-1:0]     hold_q,      hold_d;
   logic [IDX_W-1:0]      idx_q,       idx_d;
   logic [NUM_STAGES-1:0] stage_q,     stage_d;
   logic                  all_ready_q, all_ready_d;
   logic                  ack_q,       ack_d;
   logic                  pending_q,   pending_d;
   logic [7:0]            loss_cnt_q,  loss_cnt_d;

   sync_bit u_lock_sync (
      .clk_i   (clock),
      .rst_n_i (reset_n),
      .d_i     (pll_lock),
      .q_o     (lock_s)
   );

   // Lock is qualified once the filter has seen enough consecutive high cycles;
   // a drop outside WAIT_LOCK is a lock loss event
   always_comb begin
      lock_ok_s   = (lock_cnt_q == LOCK_MAX);
      lock_lost_s = (!lock_s) && (state_q != WAIT_LOCK);
   end

   // Lock filter: count consecutive synced-high cycles, hold at the qualify
   // threshold, restart on any low cycle
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (!lock_s) begin
         lock_cnt_d = LOCK_ZERO;
      end else if (lock_cnt_q != LOCK_MAX) begin
         lock_cnt_d = lock_cnt_q + LOCK_ONE;
      end else begin
         lock_cnt_d = lock_cnt_q;
      end
   end

   // Next-state, counter and output values; lock loss overrides everything else
   always_comb begin
      state_d     = state_q;
      dly_d       = dly_q;
      hold_d      = hold_q;
      idx_d       = idx_q;
      stage_d     = stage_q;
      all_ready_d = all_ready_q;
      ack_d       = 1'b0;
      pending_d   = pending_q;
      loss_cnt_d  = loss_cnt_q;

      if (lock_lost_s) begin
         state_d     = WAIT_LOCK;
         stage_d     = {NUM_STAGES{1'b0}};
         all_ready_d = 1'b0;
         loss_cnt_d  = sat_inc8(loss_cnt_q);
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               stage_d     = {NUM_STAGES{1'b0}};
               all_ready_d = 1'b0;
               if (lock_ok_s) begin
                  state_d = RELEASE;
                  idx_d   = IDX_ZERO;
                  dly_d   = DLY_ZERO;
               end else begin
                  state_d = WAIT_LOCK;
               end
            end

            RELEASE: begin
               if (dly_q == DLY_LAST) begin
                  // Released bits are sticky; only the indexed stage is added
                  for (int k = 0; k < NUM_STAGES; k++) begin
                     stage_d[k] = stage_q[k] | (idx_q == IDX_W'(k));
                  end
                  dly_d = DLY_ZERO;
                  idx_d = idx_q + IDX_ONE;
                  if (idx_q == IDX_LAST) begin
                     state_d     = RUN;
                     all_ready_d = 1'b1;
                     ack_d       = pending_q;
                     pending_d   = 1'b0;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  dly_d = dly_q + DLY_ONE;
               end
            end

            RUN: begin
               if (soft_reset_req) begin
                  state_d     = SOFT;
                  stage_d     = {NUM_STAGES{1'b0}};
                  all_ready_d = 1'b0;
                  hold_d      = HOLD_ZERO;
                  // Remember the request so it survives a lock loss during recovery
                  pending_d   = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end

            SOFT: begin
               if (hold_q == HOLD_LAST) begin
                  state_d = RELEASE;
                  idx_d   = IDX_ZERO;
                  dly_d   = DLY_ZERO;
               end else begin
                  hold_d = hold_q + HOLD_ONE;
               end
            end

            default: begin
               state_d     = WAIT_LOCK;
               stage_d     = {NUM_STAGES{1'b0}};
               all_ready_d = 1'b0;
            end
         endcase
      end
   end

   // State, counter and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= WAIT_LOCK;
         lock_cnt_q  <= LOCK_ZERO;
         dly_q       <= DLY_ZERO;
         hold_q      <= HOLD_ZERO;
         idx_q       <= IDX_ZERO;
         stage_q     <= {NUM_STAGES{1'b0}};
         all_ready_q <= 1'b0;
         ack_q       <= 1'b0;
         pending_q   <= 1'b0;
         loss_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         lock_cnt_q  <= lock_cnt_d;
         dly_q       <= dly_d;
         hold_q      <= hold_d;
         idx_q       <= idx_d;
         stage_q     <= stage_d;
         all_ready_q <= all_ready_d;
         ack_q       <= ack_d;
         pending_q   <= pending_d;
         loss_cnt_q  <= loss_cnt_d;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      stage_reset_n  = stage_q;
      all_ready      = all_ready_q;
      soft_reset_ack = ack_q;
      lock_loss_cnt  = loss_cnt_q;
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer at default parameters.
module tb_reset_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       pll_lock;
   logic       soft_reset_req;
   logic       soft_reset_ack;
   logic [2:0] stage_reset_n;
   logic       all_ready;
   logic [7:0] lock_loss_cnt;

   int checks   = 0;
   int errors   = 0;
   int ack_seen = 0;

   reset_sequencer #(
      .NUM_STAGES  (3),
      .STAGE_DELAY (16),
      .LOCK_FILTER (8),
      .SOFT_HOLD   (4)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .pll_lock       (pll_lock),
      .soft_reset_req (soft_reset_req),
      .soft_reset_ack (soft_reset_ack),
      .stage_reset_n  (stage_reset_n),
      .all_ready      (all_ready),
      .lock_loss_cnt  (lock_loss_cnt)
   );

   always #5 clock = ~clock;

   // Count ack pulses, sampled mid-cycle
   always @(negedge clock) begin
      if (soft_reset_ack === 1'b1) ack_seen++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Hold reset for 5 edges, then release with the given lock level
   task automatic do_reset(input logic lock_lvl);
      reset_n        = 1'b0;
      soft_reset_req = 1'b0;
      pll_lock       = lock_lvl;
      tick(5);
      reset_n = 1'b1;
   endtask

   // Reset with lock present and run until every stage is released (edge 59)
   task automatic reach_run();
      do_reset(1'b1);
      tick(59);
   endtask

   task automatic test_reset();
      int a0;
      reset_n = 1'b0; pll_lock = 1'b1; soft_reset_req = 1'b0;
      tick(5);
      a0 = ack_seen;
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL rst_stage: got %b exp %b", stage_reset_n, 3'b000); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", all_ready); end
      checks++; if (soft_reset_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b exp 0", soft_reset_ack); end
      checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", lock_loss_cnt); end
      reset_n = 1'b1;
      tick(26);  // edge 26: RELEASE entered at 11, nothing released yet
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL pwr_pre0: got %b exp %b", stage_reset_n, 3'b000); end
      tick(1);   // edge 27
      checks++; if (stage_reset_n !== 3'b001) begin errors++; $display("FAIL pwr_stage0: got %b exp %b", stage_reset_n, 3'b001); end
      tick(16);  // edge 43
      checks++; if (stage_reset_n !== 3'b011) begin errors++; $display("FAIL pwr_stage1: got %b exp %b", stage_reset_n, 3'b011); end
      tick(15);  // edge 58
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL pwr_ready_early: got %b exp 0", all_ready); end
      tick(1);   // edge 59
      checks++; if (stage_reset_n !== 3'b111) begin errors++; $display("FAIL pwr_stage2: got %b exp %b", stage_reset_n, 3'b111); end
      checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL pwr_ready: got %b exp 1", all_ready); end
      checks++; if (ack_seen - a0 !== 0) begin errors++; $display("FAIL pwr_no_ack: got %0d pulses exp 0", ack_seen - a0); end
   endtask

   task automatic test_lock_glitch();
      do_reset(1'b0);
      pll_lock = 1'b1;
      tick(5);
      pll_lock = 1'b0;   // one low sample at edge 6
      tick(1);
      pll_lock = 1'b1;
      tick(26);          // edge 32: RELEASE entered at 17
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL glitch_pre0: got %b exp %b", stage_reset_n, 3'b000); end
      tick(1);           // edge 33
      checks++; if (stage_reset_n !== 3'b001) begin errors++; $display("FAIL glitch_stage0: got %b exp %b", stage_reset_n, 3'b001); end
   endtask

   task automatic test_soft_reset();
      int a0;
      reach_run();
      a0 = ack_seen;
      soft_reset_req = 1'b1;
      tick(1);   // F1: SOFT
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL soft_stage: got %b exp %b", stage_reset_n, 3'b000); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL soft_ready: got %b exp 0", all_ready); end
      tick(19);  // F20: RELEASE entered at F5
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL soft_pre0: got %b exp %b", stage_reset_n, 3'b000); end
      tick(1);   // F21
      checks++; if (stage_reset_n !== 3'b001) begin errors++; $display("FAIL soft_stage0: got %b exp %b", stage_reset_n, 3'b001); end
      tick(32);  // F53
      checks++; if (stage_reset_n !== 3'b111) begin errors++; $display("FAIL soft_stage2: got %b exp %b", stage_reset_n, 3'b111); end
      checks++; if (soft_reset_ack !== 1'b1) begin errors++; $display("FAIL soft_ack: got %b exp 1", soft_reset_ack); end
      soft_reset_req = 1'b0;
      tick(1);   // F54
      checks++; if (soft_reset_ack !== 1'b0) begin errors++; $display("FAIL soft_ack_width: got %b exp 0", soft_reset_ack); end
      checks++; if (stage_reset_n !== 3'b111) begin errors++; $display("FAIL soft_stay_run: got %b exp %b", stage_reset_n, 3'b111); end
      checks++; if (ack_seen - a0 !== 1) begin errors++; $display("FAIL soft_ack_count: got %0d exp 1", ack_seen - a0); end
   endtask

   task automatic test_back_to_back();
      int a0;
      reach_run();
      a0 = ack_seen;
      soft_reset_req = 1'b1;
      tick(53);  // F53: ack
      checks++; if (soft_reset_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b exp 1", soft_reset_ack); end
      tick(1);   // F54: request still high, new SOFT
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL b2b_resoft: got %b exp %b", stage_reset_n, 3'b000); end
      soft_reset_req = 1'b0;
      tick(52);  // F106: RELEASE at F58, last stage at F106
      checks++; if (stage_reset_n !== 3'b111) begin errors++; $display("FAIL b2b_run: got %b exp %b", stage_reset_n, 3'b111); end
      checks++; if (soft_reset_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %b exp 1", soft_reset_ack); end
      tick(1);
      checks++; if (ack_seen - a0 !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d exp 2", ack_seen - a0); end
   endtask

   task automatic test_lock_loss_run();
      reach_run();
      pll_lock = 1'b0;
      tick(2);
      checks++; if (stage_reset_n !== 3'b111) begin errors++; $display("FAIL loss_sync_delay: got %b exp %b", stage_reset_n, 3'b111); end
      tick(1);
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL loss_stage: got %b exp %b", stage_reset_n, 3'b000); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL loss_ready: got %b exp 0", all_ready); end
      checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt: got %0d exp 1", lock_loss_cnt); end
      pll_lock = 1'b1;
      tick(58);
      checks++; if (stage_reset_n !== 3'b011) begin errors++; $display("FAIL loss_relock_mid: got %b exp %b", stage_reset_n, 3'b011); end
      tick(1);
      checks++; if (all_ready !== 1'b1) begin errors++; $display("FAIL loss_relock_run: got %b exp 1", all_ready); end
      checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt_hold: got %0d exp 1", lock_loss_cnt); end
   endtask

   task automatic test_loss_in_soft();
      int a0;
      reach_run();
      a0 = ack_seen;
      soft_reset_req = 1'b1;
      tick(1);   // I1: SOFT
      pll_lock = 1'b0;
      tick(3);   // I4: lock loss while in SOFT
      checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL lsoft_cnt: got %0d exp 1", lock_loss_cnt); end
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL lsoft_stage: got %b exp %b", stage_reset_n, 3'b000); end
      pll_lock = 1'b1;
      tick(58);  // J58
      checks++; if (ack_seen - a0 !== 0) begin errors++; $display("FAIL lsoft_early_ack: got %0d exp 0", ack_seen - a0); end
      tick(1);   // J59: RUN
      checks++; if (soft_reset_ack !== 1'b1) begin errors++; $display("FAIL lsoft_ack: got %b exp 1", soft_reset_ack); end
      soft_reset_req = 1'b0;
      tick(1);
      checks++; if (ack_seen - a0 !== 1) begin errors++; $display("FAIL lsoft_ack_count: got %0d exp 1", ack_seen - a0); end
   endtask

   task automatic test_same_cycle_loss();
      do_reset(1'b1);
      tick(24);
      pll_lock = 1'b0;  // lock_s low exactly when stage 0 would release (edge 27)
      tick(3);
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL same_cycle_stage: got %b exp %b", stage_reset_n, 3'b000); end
      checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL same_cycle_cnt: got %0d exp 1", lock_loss_cnt); end
      pll_lock = 1'b1;
   endtask

   task automatic test_reset_mid();
      int a0;
      reach_run();
      a0 = ack_seen;
      soft_reset_req = 1'b1;
      tick(1);
      pll_lock = 1'b0;
      tick(3);
      pll_lock = 1'b1;
      tick(43);  // J43: pending ack, one loss counted
      checks++; if (stage_reset_n !== 3'b011) begin errors++; $display("FAIL mid_pre: got %b exp %b", stage_reset_n, 3'b011); end
      reset_n = 1'b0;
      soft_reset_req = 1'b0;
      tick(1);
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL mid_stage: got %b exp %b", stage_reset_n, 3'b000); end
      checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d exp 0", lock_loss_cnt); end
      tick(4);
      reset_n = 1'b1;
      tick(59);
      checks++; if (stage_reset_n !== 3'b111) begin errors++; $display("FAIL mid_rerun: got %b exp %b", stage_reset_n, 3'b111); end
      checks++; if (ack_seen - a0 !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d exp 0", ack_seen - a0); end
   endtask

   task automatic test_saturation();
      do_reset(1'b0);
      for (int i = 0; i < 256; i++) begin
         pll_lock = 1'b1;
         tick(11);   // RELEASE entered
         pll_lock = 1'b0;
         tick(3);    // lock loss registered
         if (i == 0) begin
            checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL sat_first: got %0d exp 1", lock_loss_cnt); end
         end
         if (i == 254) begin
            checks++; if (lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d exp 255", lock_loss_cnt); end
         end
      end
      checks++; if (lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d exp 255", lock_loss_cnt); end
      checks++; if (stage_reset_n !== 3'b000) begin errors++; $display("FAIL sat_stage: got %b exp %b", stage_reset_n, 3'b000); end
   endtask

   initial begin
      reset_n        = 1'b0;
      pll_lock       = 1'b0;
      soft_reset_req = 1'b0;
      test_reset();
      test_lock_glitch();
      test_soft_reset();
      test_back_to_back();
      test_lock_loss_run();
      test_loss_in_soft();
      test_same_cycle_loss();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
